// File: rtl/bk_pkg.sv
// Shared definitions for the Brent-Kung frame accumulator.
package bk_pkg;
  localparam int DATA_W = 16;
  localparam int SUM_W  = DATA_W + 1;

  typedef enum logic {ST_ACC, ST_DONE} accum_state_t;
endpackage

// File: rtl/BK_adder.sv
// Combinational 16-bit Brent-Kung adder with carry-out in sum[16].
module BK_adder
  import bk_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [SUM_W-1:0]  sum
);
  localparam int LOG_W = $clog2(DATA_W);

  logic [DATA_W-1:0] gen0;
  logic [DATA_W-1:0] prop0;
  logic [DATA_W-1:0] grp_g;

  assign gen0  = a & b;
  assign prop0 = a ^ b;

  // Up-sweep builds power-of-two spans; down-sweep fills the remaining prefixes.
  always_comb begin : prefix
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] p;
    g = gen0;
    p = prop0;
    for (int lvl = 0; lvl < LOG_W; lvl++) begin
      for (int i = 0; i < DATA_W; i++) begin
        if (((i + 1) % (2 << lvl)) == 0) begin
          g[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
          p[i] = p[i] & p[i - (1 << lvl)];
        end
      end
    end
    for (int lvl = LOG_W - 2; lvl >= 0; lvl--) begin
      for (int i = 0; i < DATA_W; i++) begin
        if ((((i + 1) % (2 << lvl)) == (1 << lvl)) && (i >= (2 << lvl))) begin
          g[i] = g[i] | (p[i] & g[i - (1 << lvl)]);
          p[i] = p[i] & p[i - (1 << lvl)];
        end
      end
    end
    grp_g = g;
  end

  // grp_g[i] is the carry out of bit i (carry-in is zero).
  assign sum = {grp_g[DATA_W-1], prop0 ^ {grp_g[DATA_W-2:0], 1'b0}};
endmodule

// File: rtl/bk_stream_accum.sv
// Streams 16-bit samples into a Brent-Kung adder and emits one widened total per frame.
module bk_stream_accum
  import bk_pkg::*;
#(
  parameter int N_SAMPLES = 16,
  parameter int EXT_W     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_W-1:0]       in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_W+EXT_W-1:0] out_sum,
  output logic                    out_ovf,
  output logic                    busy
);
  localparam int CNT_W = $clog2(N_SAMPLES + 1);

  accum_state_t      state_reg, state_next;
  logic [DATA_W-1:0] acc_lo_reg, acc_lo_next;
  logic [EXT_W-1:0]  acc_hi_reg, acc_hi_next;
  logic              ovf_reg, ovf_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [SUM_W-1:0]  add_sum;

  BK_adder u_adder (
    .a   (acc_lo_reg),
    .b   (in_data),
    .sum (add_sum)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_ACC;
      acc_lo_reg <= '0;
      acc_hi_reg <= '0;
      ovf_reg    <= 1'b0;
      cnt_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      acc_lo_reg <= acc_lo_next;
      acc_hi_reg <= acc_hi_next;
      ovf_reg    <= ovf_next;
      cnt_reg    <= cnt_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    acc_lo_next = acc_lo_reg;
    acc_hi_next = acc_hi_reg;
    ovf_next    = ovf_reg;
    cnt_next    = cnt_reg;
    in_ready    = 1'b0;
    if (clr) begin
      // Abort wins over any handshake and drops the frame silently.
      state_next  = ST_ACC;
      acc_lo_next = '0;
      acc_hi_next = '0;
      ovf_next    = 1'b0;
      cnt_next    = '0;
    end else begin
      case (state_reg)
        ST_ACC: begin
          in_ready = 1'b1;
          if (in_valid) begin
            acc_lo_next = add_sum[DATA_W-1:0];
            acc_hi_next = acc_hi_reg + EXT_W'(add_sum[DATA_W]);
            ovf_next    = ovf_reg | (add_sum[DATA_W] & (&acc_hi_reg));
            cnt_next    = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(N_SAMPLES - 1)) begin
              state_next = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_next  = ST_ACC;
            acc_lo_next = '0;
            acc_hi_next = '0;
            ovf_next    = 1'b0;
            cnt_next    = '0;
          end
        end
        default: state_next = ST_ACC;
      endcase
    end
  end

  assign out_valid = (state_reg == ST_DONE);
  assign out_sum   = {acc_hi_reg, acc_lo_reg};
  assign out_ovf   = ovf_reg;
  assign busy      = (state_reg == ST_DONE) || (cnt_reg != '0);
endmodule

// File: tb/tb_bk_stream_accum.sv
// Random and directed frames into two accumulators (EXT_W=8 and EXT_W=1) checked by a scoreboard.
module tb_bk_stream_accum;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, clr, in_valid, out_ready;
  logic [15:0] in_data;

  logic        in_ready_a, out_valid_a, out_ovf_a, busy_a;
  logic [23:0] out_sum_a;
  logic        in_ready_b, out_valid_b, out_ovf_b, busy_b;
  logic [16:0] out_sum_b;

  int total_cnt = 0;
  int bad_cnt   = 0;

  longint exp_a[$];
  longint exp_b[$];
  longint part_total = 0;
  int     part_cnt   = 0;
  bit     rand_ready_en = 1'b0;
  bit     ready_force   = 1'b1;

  always #5 clk = ~clk;

  bk_stream_accum #(.N_SAMPLES(N), .EXT_W(8)) dut_a (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .out_valid(out_valid_a), .out_ready(out_ready),
    .out_sum(out_sum_a), .out_ovf(out_ovf_a), .busy(busy_a)
  );

  bk_stream_accum #(.N_SAMPLES(N), .EXT_W(1)) dut_b (
    .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_sum(out_sum_b), .out_ovf(out_ovf_b), .busy(busy_b)
  );

  task automatic check(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act != exp) begin
      bad_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic longint wrap(input longint t, input int w);
    return t & ((longint'(1) << w) - 1);
  endfunction

  // Reference: a frame total is the plain integer sum of its samples.
  task automatic model_accept(input logic [15:0] d);
    part_total += longint'(d);
    part_cnt++;
    if (part_cnt == N) begin
      exp_a.push_back(part_total);
      exp_b.push_back(part_total);
      $display("frame queued: total=0x%0h", part_total);
      part_total = 0;
      part_cnt   = 0;
    end
  endtask

  task automatic model_abort();
    part_total = 0;
    part_cnt   = 0;
  endtask

  task automatic send(input logic [15:0] d);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int c = 0; c < 300 && !ok; c++) begin
      @(negedge clk);
      ok = in_ready_a;
      @(posedge clk);
    end
    if (!ok) check("accept_timeout", 0, 1);
    else model_accept(d);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_in_ready"},  in_ready_a,  1);
    check({tag, "_out_valid"}, out_valid_a, 0);
    check({tag, "_out_sum"},   out_sum_a,   0);
    check({tag, "_out_ovf"},   out_ovf_a,   0);
    check({tag, "_busy"},      busy_a,      0);
    check({tag, "_b_out_sum"}, out_sum_b,   0);
    check({tag, "_b_valid"},   out_valid_b, 0);
  endtask

  task automatic drain();
    for (int c = 0; c < 300 && (exp_a.size() != 0 || exp_b.size() != 0); c++) @(posedge clk);
    #1;
    check("drain_a_pending", exp_a.size(), 0);
    check("drain_b_pending", exp_b.size(), 0);
  endtask

  // out_ready has a single writer: random or forced level, updated just after each edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = rand_ready_en ? 1'($urandom_range(0, 1)) : ready_force;
    end
  end

  // Monitors: a handshake seen at the falling edge completes on the next rising edge.
  initial begin
    longint t;
    forever begin
      @(negedge clk);
      if (!rst && out_valid_a && out_ready) begin
        if (exp_a.size() == 0) begin
          check("a_unexpected_output", 1, 0);
        end else begin
          t = exp_a.pop_front();
          $display("out a: sum=0x%0h ovf=%0d exp=0x%0h", out_sum_a, out_ovf_a, wrap(t, 24));
          check("a_out_sum", out_sum_a, wrap(t, 24));
          check("a_out_ovf", out_ovf_a, longint'((t >> 24) != 0));
        end
      end
    end
  end

  initial begin
    longint t;
    forever begin
      @(negedge clk);
      if (!rst && out_valid_b && out_ready) begin
        if (exp_b.size() == 0) begin
          check("b_unexpected_output", 1, 0);
        end else begin
          t = exp_b.pop_front();
          $display("out b: sum=0x%0h ovf=%0d exp=0x%0h", out_sum_b, out_ovf_b, wrap(t, 17));
          check("b_out_sum", out_sum_b, wrap(t, 17));
          check("b_out_ovf", out_ovf_b, longint'((t >> 17) != 0));
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exceeded limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;
    idle(1);

    // Small frame back-to-back: valid appears right after the 4th accept.
    send(16'h0001);
    send(16'h0002);
    check("busy_mid_frame", busy_a, 1);
    send(16'h0003);
    check("valid_early", out_valid_a, 0);
    send(16'h0004);
    check("valid_cycle5", out_valid_a, 1);
    check("in_ready_done", in_ready_a, 0);
    drain();

    // Carry into the extension bits; the 1-bit extension overflows.
    for (int k = 0; k < N; k++) send(16'hFFFF);
    drain();

    // Backpressure for 10 cycles while the next frame's first sample waits.
    ready_force = 1'b0;
    idle(2);
    for (int k = 0; k < N; k++) send(16'($urandom));
    fork
      begin
        for (int k = 0; k < N; k++) send(16'h0010);
      end
      begin
        longint front;
        front = wrap(exp_a[0], 24);
        for (int k = 0; k < 10; k++) begin
          @(negedge clk);
          check("bp_in_ready", in_ready_a, 0);
          check("bp_out_valid", out_valid_a, 1);
          check("bp_out_sum_stable", out_sum_a, front);
        end
        ready_force = 1'b1;
      end
    join
    drain();

    // Abort after two samples; sample offered during clr is refused.
    send(16'($urandom));
    send(16'($urandom));
    check("busy_before_clr", busy_a, 1);
    clr = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF;
    @(negedge clk);
    check("clr_blocks_in", in_ready_a, 0);
    @(posedge clk);
    #1;
    clr = 1'b0; in_valid = 1'b0;
    model_abort();
    check("busy_after_clr", busy_a, 0);
    for (int k = 0; k < N; k++) send(16'h0005);
    drain();

    // Reset mid-frame with in_valid wiggling.
    for (int k = 0; k < 3; k++) send(16'($urandom));
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 16'($urandom);
      @(posedge clk);
      #1;
      check_reset_vals("midrst");
    end
    rst = 1'b0; in_valid = 1'b0;
    model_abort();
    exp_a.delete();
    exp_b.delete();
    for (int k = 0; k < N; k++) send(16'($urandom));
    drain();

    // Random frames, random gaps, random downstream readiness.
    rand_ready_en = 1'b1;
    for (int f = 0; f < 20; f++) begin
      for (int k = 0; k < N; k++) begin
        d = (f % 2 == 0) ? 16'($urandom) : 16'($urandom_range(16'hF000, 16'hFFFF));
        if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        send(d);
      end
    end
    rand_ready_en = 1'b0;
    ready_force   = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end
endmodule
